// File: rtl/coef_pkg.sv
// rtl/coef_pkg.sv - shared constants, types and address helpers for the coefficient sequencer
//
// Holds bank geometry (NUM_TAPS, COEF_W), the config address map for the
// eight bank halves, the bank storage type, the sequencer state encoding and
// small decode/pack helpers used by coef_sequencer and coef_bank.
// Optional feature macro: COEF_READBACK_EN (uses pack_half for readback).

package coef_pkg;

    localparam int NUM_TAPS  = 8;
    localparam int COEF_W    = 5;
    localparam int TAP_W     = $clog2(NUM_TAPS);
    localparam int HALF_TAPS = NUM_TAPS / 2;
    localparam int HIDX_W    = $clog2(HALF_TAPS);
    localparam int HALF_W    = HALF_TAPS * COEF_W;

    // Odd address = first half (taps 0..3), even address = second half (taps 4..7).
    localparam int unsigned ADDR_COS1_F = 1;
    localparam int unsigned ADDR_COS1_S = 2;
    localparam int unsigned ADDR_SIN1_F = 3;
    localparam int unsigned ADDR_SIN1_S = 4;
    localparam int unsigned ADDR_COS2_F = 5;
    localparam int unsigned ADDR_COS2_S = 6;
    localparam int unsigned ADDR_SIN2_F = 7;
    localparam int unsigned ADDR_SIN2_S = 8;

    typedef logic [NUM_TAPS-1:0][COEF_W-1:0]  coef_bank_t;
    // Element 0 of a half sits in the most significant slice of the word.
    typedef logic [HALF_TAPS-1:0][COEF_W-1:0] half_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    function automatic logic addr_valid(input int unsigned a);
        return (a >= ADDR_COS1_F) && (a <= ADDR_SIN2_S);
    endfunction

    // Bank order: 0 = cos1, 1 = sin1, 2 = cos2, 3 = sin2. Only meaningful when addr_valid.
    function automatic logic [1:0] addr_bank(input int unsigned a);
        return 2'((a - 1) >> 1);
    endfunction

    function automatic logic addr_half(input int unsigned a);
        return (a[0] == 1'b0);
    endfunction

    function automatic logic [HALF_W-1:0] pack_half(input coef_bank_t b, input logic half);
        half_t r;
        r = '0;
        for (int i = 0; i < HALF_TAPS; i++) begin
            r[HIDX_W'(HALF_TAPS - 1 - i)] = b[TAP_W'((half ? HALF_TAPS : 0) + i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/coef_bank.sv
// rtl/coef_bank.sv - shadow/active coefficient pair for one channel with tap-indexed registered read
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   wr_en, wr_half    half-bank write strobe; wr_half=0 taps 0..3, 1 taps 4..7
//   wr_data           four packed coefficients, element 0 in the top slice
//   copy              shadow -> active copy strobe
//   tap_next          tap index that will be current after this edge
//   coef              registered active coefficient at the current tap
//   active            (COEF_READBACK_EN only) whole active bank for readback

module coef_bank
    import coef_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_half,
    input  half_t             wr_data,
    input  logic              copy,
    input  logic [TAP_W-1:0]  tap_next,
    output logic [COEF_W-1:0] coef
`ifdef COEF_READBACK_EN
    ,
    output coef_bank_t        active
`endif
);

    coef_bank_t        shadow_q, shadow_d;
    coef_bank_t        active_q, active_d;
    logic [COEF_W-1:0] coef_q, coef_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            for (int i = 0; i < HALF_TAPS; i++) begin
                shadow_d[TAP_W'((wr_half ? HALF_TAPS : 0) + i)] = wr_data[HIDX_W'(HALF_TAPS - 1 - i)];
            end
        end
        // The copy takes shadow_q, so a write on the same edge lands only in the shadow.
        active_d = copy ? shadow_q : active_q;
        // Read from the next-state bank at the next-state tap so the output
        // always lines up with tap_idx, including a copy at the wrap.
        coef_d   = active_d[tap_next];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            coef_q   <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            coef_q   <= coef_d;
        end
    end

    assign coef = coef_q;
`ifdef COEF_READBACK_EN
    assign active = active_q;
`endif

endmodule

// File: rtl/coef_sequencer.sv
// rtl/coef_sequencer.sv - delta-sigma weight bank owner: shadow load, frame-aligned commit, tap sequencing
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   cfg_we/cfg_addr/cfg_data half-bank shadow write (addr 1..8), invalid addr sets cfg_err
//   run, tick               sequencer enable, sample-rate tap advance
//   commit_req              request shadow -> active copy
//   commit_ack, commit_pend copy-done pulse, request waiting for frame boundary
//   cfg_err                 sticky invalid-address flag, cleared by a commit
//   tap_idx, frame_start    current tap, one-cycle pulse on wrap to tap 0
//   cos1/sin1/cos2/sin2_coef active coefficients at tap_idx
//   rd_addr, rd_data        (COEF_READBACK_EN only) registered active half readback
// Optional feature macro: COEF_READBACK_EN.

module coef_sequencer
    import coef_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [HALF_W-1:0] cfg_data,
`ifdef COEF_READBACK_EN
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [HALF_W-1:0] rd_data,
`endif
    input  logic              run,
    input  logic              tick,
    input  logic              commit_req,
    output logic              commit_ack,
    output logic              commit_pend,
    output logic              cfg_err,
    output logic [TAP_W-1:0]  tap_idx,
    output logic              frame_start,
    output logic [COEF_W-1:0] cos1_coef,
    output logic [COEF_W-1:0] sin1_coef,
    output logic [COEF_W-1:0] cos2_coef,
    output logic [COEF_W-1:0] sin2_coef
);

    state_e            state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic              ack_q, ack_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              fs_q, fs_d;
    logic              copy;
    logic              wrap;
    logic [TAP_W-1:0]  tap_inc;

    logic              cfg_valid;
    logic [1:0]        cfg_bank;
    logic              cfg_half;
    logic [3:0]        bank_we;
    logic [COEF_W-1:0] bank_coef [4];

    assign cfg_valid = addr_valid(32'(cfg_addr));
    assign cfg_bank  = addr_bank(32'(cfg_addr));
    assign cfg_half  = addr_half(32'(cfg_addr));

    assign wrap    = tick && (tap_q == TAP_W'(NUM_TAPS - 1));
    assign tap_inc = wrap ? '0 : tap_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        ack_d   = 1'b0;
        fs_d    = 1'b0;
        pend_d  = pend_q;
        err_d   = err_q;
        copy    = 1'b0;

        case (state_q)
            IDLE: begin
                tap_d = '0;
                if (commit_req) begin
                    copy  = 1'b1;
                    ack_d = 1'b1;
                end
                if (run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = IDLE;
                    tap_d   = '0;
                    // Stopping is itself a safe boundary, so a request here is served at once.
                    if (commit_req) begin
                        copy  = 1'b1;
                        ack_d = 1'b1;
                    end
                end else begin
                    if (tick) begin
                        tap_d = tap_inc;
                        fs_d  = wrap;
                    end
                    if (commit_req) begin
                        state_d = PEND;
                        pend_d  = 1'b1;
                    end
                end
            end
            PEND: begin
                // Further commit_req pulses are absorbed while waiting.
                if (!run) begin
                    copy    = 1'b1;
                    ack_d   = 1'b1;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                    tap_d   = '0;
                end else if (tick) begin
                    tap_d = tap_inc;
                    if (wrap) begin
                        copy    = 1'b1;
                        ack_d   = 1'b1;
                        fs_d    = 1'b1;
                        pend_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tap_d   = '0;
                pend_d  = 1'b0;
            end
        endcase

        // A new invalid write wins over the clear from a simultaneous copy.
        if (copy) begin
            err_d = 1'b0;
        end
        if (cfg_we && !cfg_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tap_q   <= '0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            fs_q    <= fs_d;
        end
    end

`ifdef COEF_READBACK_EN
    coef_bank_t bank_active [4];
`endif

    for (genvar g = 0; g < 4; g++) begin : g_bank
        assign bank_we[g] = cfg_we && cfg_valid && (cfg_bank == 2'(g));

        coef_bank u_bank (
            .clock    (clock),
            .reset    (reset),
            .wr_en    (bank_we[g]),
            .wr_half  (cfg_half),
            .wr_data  (cfg_data),
            .copy     (copy),
            .tap_next (tap_d),
            .coef     (bank_coef[g])
`ifdef COEF_READBACK_EN
            ,
            .active   (bank_active[g])
`endif
        );
    end

`ifdef COEF_READBACK_EN
    logic [HALF_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (addr_valid(32'(rd_addr))) begin
            rd_data_d = pack_half(bank_active[addr_bank(32'(rd_addr))], addr_half(32'(rd_addr)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

    assign commit_ack  = ack_q;
    assign commit_pend = pend_q;
    assign cfg_err     = err_q;
    assign tap_idx     = tap_q;
    assign frame_start = fs_q;
    assign cos1_coef   = bank_coef[0];
    assign sin1_coef   = bank_coef[1];
    assign cos2_coef   = bank_coef[2];
    assign sin2_coef   = bank_coef[3];

endmodule

// File: tb/tb_coef_sequencer.sv
// tb/tb_coef_sequencer.sv - directed self-checking bench for coef_sequencer

module tb_coef_sequencer;

    logic        clock;
    logic        reset;
    logic        cfg_we;
    logic [6:0]  cfg_addr;
    logic [19:0] cfg_data;
    logic        run;
    logic        tick;
    logic        commit_req;
    logic        commit_ack;
    logic        commit_pend;
    logic        cfg_err;
    logic [2:0]  tap_idx;
    logic        frame_start;
    logic [4:0]  cos1_coef;
    logic [4:0]  sin1_coef;
    logic [4:0]  cos2_coef;
    logic [4:0]  sin2_coef;
`ifdef COEF_READBACK_EN
    logic [6:0]  rd_addr;
    logic [19:0] rd_data;
`endif

    int n_checks;
    int n_fail;

    coef_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
`ifdef COEF_READBACK_EN
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
`endif
        .run         (run),
        .tick        (tick),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .commit_pend (commit_pend),
        .cfg_err     (cfg_err),
        .tap_idx     (tap_idx),
        .frame_start (frame_start),
        .cos1_coef   (cos1_coef),
        .sin1_coef   (sin1_coef),
        .cos2_coef   (cos2_coef),
        .sin2_coef   (sin2_coef)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [6:0] a, input logic [19:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        run        = 1'b0;
        tick       = 1'b0;
        commit_req = 1'b0;
`ifdef COEF_READBACK_EN
        rd_addr    = '0;
`endif

        // Reset state
        step();
        step();
        chk("rst_tap",  32'(tap_idx), 0);
        chk("rst_ack",  32'(commit_ack), 0);
        chk("rst_pend", 32'(commit_pend), 0);
        chk("rst_err",  32'(cfg_err), 0);
        chk("rst_fs",   32'(frame_start), 0);
        chk("rst_coef", 32'({cos1_coef, sin1_coef, cos2_coef, sin2_coef}), 0);
        reset = 1'b0;
        step();

        // sin1 = 1..8, commit in IDLE, then a full frame
        write(7'd3, {5'd1, 5'd2, 5'd3, 5'd4});
        write(7'd4, {5'd5, 5'd6, 5'd7, 5'd8});
        chk("shadow_only_sin1", 32'(sin1_coef), 0);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("idle_ack", 32'(commit_ack), 1);
        chk("idle_sin1_t0", 32'(sin1_coef), 1);
        run = 1'b1;
        step();
        chk("idle_ack_drop", 32'(commit_ack), 0);
        tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("frame1_tap%0d", k), 32'(tap_idx), 32'(k % 8));
            chk($sformatf("frame1_sin1_%0d", k), 32'(sin1_coef), 32'((k % 8) + 1));
            chk($sformatf("frame1_fs_%0d", k), 32'(frame_start), (k == 8) ? 1 : 0);
            chk($sformatf("frame1_cos1_%0d", k), 32'(cos1_coef), 0);
        end
        tick = 1'b0;
        run  = 1'b0;
        step();
        chk("stop_tap", 32'(tap_idx), 0);

        // Bank A (all 3) active, bank B (all 9) committed mid-frame
        write(7'd5, {4{5'd3}});
        write(7'd6, {4{5'd3}});
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("bankA_cos2", 32'(cos2_coef), 3);
        run = 1'b1;
        step();
        write(7'd5, {4{5'd9}});
        write(7'd6, {4{5'd9}});
        tick = 1'b1;
        step();
        step();
        chk("pre_commit_tap", 32'(tap_idx), 2);
        tick = 1'b0;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("pend_set", 32'(commit_pend), 1);
        chk("pend_tap2_cos2", 32'(cos2_coef), 3);
        tick = 1'b1;
        for (int t = 3; t <= 7; t++) begin
            commit_req = (t == 4);
            step();
            chk($sformatf("pend_tap%0d", t), 32'(tap_idx), 32'(t));
            chk($sformatf("pend_cos2_%0d", t), 32'(cos2_coef), 3);
            chk($sformatf("pend_hold_%0d", t), 32'(commit_pend), 1);
            chk($sformatf("pend_noack_%0d", t), 32'(commit_ack), 0);
        end
        commit_req = 1'b0;
        step();
        chk("wrap_tap", 32'(tap_idx), 0);
        chk("wrap_cos2", 32'(cos2_coef), 9);
        chk("wrap_ack", 32'(commit_ack), 1);
        chk("wrap_fs", 32'(frame_start), 1);
        chk("wrap_pend_clr", 32'(commit_pend), 0);
        tick = 1'b0;
        step();
        chk("wrap_single_ack", 32'(commit_ack), 0);
        chk("wrap_fs_drop", 32'(frame_start), 0);
        chk("wrap_no_repend", 32'(commit_pend), 0);
        chk("wrap_cos2_hold", 32'(cos2_coef), 9);

        // Invalid addresses
        run = 1'b0;
        step();
        write(7'd9, 20'hFFFFF);
        chk("err_set", 32'(cfg_err), 1);
        chk("err_nochg", 32'({cos1_coef, sin1_coef, cos2_coef, sin2_coef}), 32'({5'd0, 5'd1, 5'd9, 5'd0}));
        write(7'd0, 20'hFFFFF);
        step();
        chk("err_sticky", 32'(cfg_err), 1);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("err_commit_ack", 32'(commit_ack), 1);
        step();
        chk("err_cleared", 32'(cfg_err), 0);
        chk("err_shadow_clean", 32'({cos1_coef, sin1_coef, cos2_coef, sin2_coef}), 32'({5'd0, 5'd1, 5'd9, 5'd0}));

        // Write and copy on the same edge
        cfg_we     = 1'b1;
        cfg_addr   = 7'd1;
        cfg_data   = {5'd10, 5'd11, 5'd12, 5'd13};
        commit_req = 1'b1;
        step();
        cfg_we     = 1'b0;
        commit_req = 1'b0;
        chk("same_edge_ack", 32'(commit_ack), 1);
        chk("same_edge_old_cos1", 32'(cos1_coef), 0);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("next_commit_cos1", 32'(cos1_coef), 10);

`ifdef COEF_READBACK_EN
        write(7'd5, 20'hABCDE);
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        rd_addr = 7'd5;
        step();
        chk("rd_addr5", 32'(rd_data), 32'h000ABCDE);
        rd_addr = 7'd0;
        step();
        chk("rd_addr0", 32'(rd_data), 0);
`endif

        // Reset while pending
        run = 1'b1;
        step();
        write(7'd7, {4{5'd17}});
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("rst_pend_set", 32'(commit_pend), 1);
        tick = 1'b1;
        step();
        step();
        reset = 1'b1;
        run   = 1'b0;
        #2;
        chk("async_rst_tap", 32'(tap_idx), 0);
        chk("async_rst_pend", 32'(commit_pend), 0);
        chk("async_rst_ack", 32'(commit_ack), 0);
        chk("async_rst_coef", 32'({cos1_coef, sin1_coef, cos2_coef, sin2_coef}), 0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("post_rst_tap_%0d", k), 32'(tap_idx), 0);
            chk($sformatf("post_rst_noack_%0d", k), 32'(commit_ack), 0);
        end
        tick = 1'b0;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("post_rst_idle_ack", 32'(commit_ack), 1);
        chk("post_rst_shadow_clr", 32'(sin2_coef), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coef_sequencer.md
Name: coef_sequencer

Overview:
- Owns the four delta-sigma weight banks: w_cos_1, w_sin_1, w_cos_2, w_sin_2, each NUM_TAPS x COEF_W.
- Decoded SPI write transactions load a shadow copy of each bank.
- A commit handshake copies the shadow banks into the active banks, but only at a frame boundary.
- The active banks are stepped tap-by-tap on the sample-rate tick and presented to the modulator datapath.

Parameters:
- NUM_TAPS, 8, taps per bank; tap index wraps NUM_TAPS-1 -> 0.
- COEF_W, 5, bits per coefficient.
- ADDR_W, 7, config address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_we  in  1  one-cycle write strobe from the SPI decode.
- cfg_addr  in  ADDR_W  bank-half address: 1/2 = cos1 first/second, 3/4 = sin1, 5/6 = cos2, 7/8 = sin2.
- cfg_data  in  4*COEF_W  packed: [19:15] = element 0 of the half, [14:10] = element 1, [9:5] = element 2, [4:0] = element 3.
- run  in  1  sequencer enable.
- tick  in  1  sample-rate enable; advances the tap.
- commit_req  in  1  request to copy shadow -> active.
- commit_ack  out  1  one-cycle pulse when the copy has happened.
- commit_pend  out  1  high while a request is waiting for a frame boundary.
- cfg_err  out  1  sticky; set by a write to an invalid address.
- tap_idx  out  clog2(NUM_TAPS)  current tap.
- frame_start  out  1  one-cycle pulse on a wrap to tap 0.
- cos1_coef, sin1_coef, cos2_coef, sin2_coef  out  COEF_W each  active coefficient at tap_idx.

Behaviour:
- Reset values:
  - All shadow and active banks = 0.
  - tap_idx = 0; all coef outputs = 0.
  - commit_ack, commit_pend, cfg_err, frame_start = 0.
  - State = IDLE.
- Shadow write:
  - On cfg_we with addr in 1..8, write elements 0-3 (first half, odd addr) or elements 4-7 (second half, even addr) at that edge.
  - Any other address: no write; cfg_err <= 1.
  - cfg_err clears only on reset or on a commit_ack.
- State machine:
  - IDLE (run=0):
    - tap_idx held at 0.
    - commit_req: active <= shadow at that edge; commit_ack pulses the next cycle.
    - run=1 -> RUN.
  - RUN:
    - On tick: tap_idx <= (tap_idx+1) mod NUM_TAPS.
    - On the wrap edge: frame_start pulses the next cycle.
    - commit_req -> PEND; commit_pend=1.
    - run=0 -> IDLE; tap_idx <= 0.
  - PEND:
    - Keeps sequencing.
    - On the tick with tap_idx==NUM_TAPS-1: active <= shadow at that edge, tap_idx <= 0, commit_ack and frame_start pulse together, commit_pend <= 0 -> RUN.
    - run=0 while pending: copy at the next edge, ack, -> IDLE.
- Coefficient outputs:
  - Registered; updated on the same edge as tap_idx (and on an active copy), so they always match tap_idx.
  - A copy at the wrap makes tap 0 of the new bank visible immediately.
- Simultaneous events:
  - cfg_we and copy on the same edge: active takes the pre-write shadow value; the shadow takes the new data.
  - commit_req while already in PEND: absorbed; one ack only.
  - tick while run=0: ignored.
- Reset mid-frame or while pending: the pending commit is discarded and no ack is issued.
- Latency:
  - Write to shadow: 1 edge.
  - Commit in IDLE: ack 1 cycle after the request.
  - Commit in RUN: ack at the next frame boundary.

Optional Feature:
- COEF_READBACK_EN defined:
  - Adds input rd_addr (ADDR_W) and output rd_data (4*COEF_W).
  - rd_data returns the active bank half selected by rd_addr, packed in the cfg_data format, registered (1-cycle latency).
  - Invalid rd_addr returns 0.
  - Reset value of rd_data is 0.
- Macro undefined: both ports are absent and no read logic exists.

Decomposition:
- Shared package (coef_pkg):
  - Address constants ADDR_COS1_F..ADDR_SIN2_S (1..8).
  - COEF_W and NUM_TAPS.
  - Typedef coef_bank_t = [NUM_TAPS-1:0][COEF_W-1:0].
  - State enum {IDLE, RUN, PEND}.
- Sub-module coef_bank:
  - Shadow + active pair for one channel: half-write port, copy strobe, tap-indexed registered read.
  - Instantiated four times.
  - The FSM and tap counter live in coef_sequencer.

Test Plan:
- Reset, then write addr 3 data {1,2,3,4} and addr 4 data {5,6,7,8}, commit in IDLE -> commit_ack 1 cycle later; with run=1 and 8 ticks, sin1_coef = 1..8 and frame_start pulses on the wrap.
- Running with bank A (all 3), write bank B (all 9), commit at tap 2 -> commit_pend=1, taps 3..7 still output 3; on the wrap, tap 0 outputs 9 with commit_ack and frame_start on the same cycle.
- cfg_we addr 9 -> no bank change, cfg_err=1; stays set until the next commit_ack, then clears.
- cfg_we to addr 1 on the same edge as a commit copy -> active keeps the old cos1 value; the next commit delivers the new one.
- Assert reset during PEND -> all outputs 0, no commit_ack, state IDLE; tick with run=0 leaves tap_idx at 0.
- With COEF_READBACK_EN: after a commit of addr 5 data 20'hABCDE, rd_addr=5 -> rd_data=20'hABCDE one cycle later; rd_addr=0 -> 0.
